// File: rtl/div_unit_seq_pkg.sv
// Shared CPU constants and divider types.
package div_unit_seq_pkg;

  localparam int CPU_W = 16;

  // Result-mux select codes; the divider quotient is picked on OP_DIV.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit_seq_if.sv
// Divider request/result bundle.
//
// Handshake: there is no separate ready; the divider accepts a request on any
// rising edge where start=1 and it is not running (state IDLE or DONE, i.e.
// busy=0). dividend/divisor are sampled on that edge only. start while busy=1
// is dropped, not queued. done is a one-cycle pulse marking fresh results,
// which then stay stable until the next done.
interface div_unit_seq_if
  import div_unit_seq_pkg::*;
#(
  parameter int N = CPU_W
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  div_state_t   state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, state
  );
endinterface

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {A,Q} left by one, try A-D,
// keep the difference and set the quotient bit if it did not go negative.
module div_restore_step #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  output logic [N-1:0] a_next,
  output logic [N-1:0] q_next
);

  // The shifted partial remainder needs N+1 bits: A < D <= 2^N-1 before the
  // shift, so 2A+1 can exceed N bits. When A_sh >= D the true difference is
  // below D, so an N-bit wrap-around subtraction gives the exact value.
  logic [N:0]   a_sh;
  logic [N-1:0] diff;
  logic         fits;

  // Shift, trial subtract, restore on borrow.
  always_comb begin
    a_sh   = {a, q[N-1]};
    fits   = (a_sh >= {1'b0, d});
    diff   = a_sh[N-1:0] - d;
    a_next = fits ? diff : a_sh[N-1:0];
    q_next = {q[N-2:0], fits};
  end

endmodule

// File: rtl/div_unit_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero short-circuits straight to DONE with all-ones quotient.
module div_unit_seq
  import div_unit_seq_pkg::*;
#(
  parameter int N = CPU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  div_unit_seq_if.slave    bus
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  div_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     a_r, q_r, d_r;
  logic [N-1:0]     a_nx, q_nx;
  logic [N-1:0]     quot_r, rem_r;
  logic             dz_r;
  logic             accept;
  logic             zero_div;

  assign accept   = bus.start && (state != DIV_RUN);
  assign zero_div = (bus.divisor == '0);

  div_restore_step #(.N(N)) u_step (
    .a      (a_r),
    .q      (q_r),
    .d      (d_r),
    .a_next (a_nx),
    .q_next (q_nx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: DONE behaves like IDLE for a new start.
  always_comb begin
    next_state = state;
    case (state)
      DIV_IDLE, DIV_DONE: begin
        if (bus.start)            next_state = zero_div ? DIV_DONE : DIV_RUN;
        else                      next_state = DIV_IDLE;
      end
      DIV_RUN: begin
        if (cnt == LAST)          next_state = DIV_DONE;
      end
      default:                    next_state = DIV_IDLE;
    endcase
  end

  // Working registers, iteration counter and committed results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_r    <= '0;
      q_r    <= '0;
      d_r    <= '0;
      quot_r <= '0;
      rem_r  <= '0;
      dz_r   <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quot_r <= '1;
        rem_r  <= bus.dividend;
        dz_r   <= 1'b1;
      end else begin
        a_r <= '0;
        q_r <= bus.dividend;
        d_r <= bus.divisor;
        cnt <= '0;
      end
    end else if (state == DIV_RUN) begin
      a_r <= a_nx;
      q_r <= q_nx;
      if (cnt == LAST) begin
        quot_r <= q_nx;
        rem_r  <= a_nx;
        dz_r   <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.busy        = (state == DIV_RUN);
  assign bus.done        = (state == DIV_DONE);
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;
  assign bus.state       = state;

endmodule

// File: tb/tb_div_unit_seq.sv
// Bench for div_unit_seq: vector table, corner-case sequences, random runs.
module tb_div_unit_seq;
  import div_unit_seq_pkg::*;

  localparam int N = 16;

  typedef struct {
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         edz;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [2*N:0] exp_q[$];

  div_unit_seq_if #(.N(N)) dif ();

  div_unit_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: plain unsigned division with the divide-by-zero convention.
  task automatic model(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                       output logic [N-1:0] eq, output logic [N-1:0] er, output logic edz);
    if (dvs == 0) begin
      eq = '1; er = dvd; edz = 1'b1;
    end else begin
      eq = N'(int'(dvd) / int'(dvs));
      er = N'(int'(dvd) % int'(dvs));
      edz = 1'b0;
    end
  endtask

  // One full transaction: issue, wait for done, check latency/results/pulse.
  task automatic run_one(input string tag, input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz);
    int cyc;
    logic busy_seen;
    logic [2*N:0] e;
    exp_q.push_back({edz, eq, er});
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = dvd; dif.divisor = dvs;
    @(negedge clk);
    dif.start = 1'b0;
    dif.dividend = N'($urandom); dif.divisor = N'($urandom);
    cyc = 1;
    busy_seen = dif.busy;
    while (!dif.done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      busy_seen |= dif.busy;
    end
    e = exp_q.pop_front();
    check({tag, " latency"}, cyc, edz ? 1 : N + 1);
    check({tag, " quotient"}, dif.quotient, e[2*N-1:N]);
    check({tag, " remainder"}, dif.remainder, e[N-1:0]);
    check({tag, " dz"}, dif.div_by_zero, e[2*N]);
    check({tag, " busy_seen"}, busy_seen, !edz);
    @(negedge clk);
    check({tag, " done_pulse"}, dif.done, 0);
    check({tag, " held_q"}, dif.quotient, e[2*N-1:N]);
  endtask

  initial begin
    vec_t vt[9];
    int cyc;
    logic seen;
    logic [N-1:0] rdvd, rdvs, req, rer;
    logic redz;

    total = 0; bad = 0;
    vt[0] = '{16'd100,  16'd7,    16'd14,    16'd2,    1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 16'hFFFF,  16'h0000, 1'b0};
    vt[2] = '{16'd7,    16'd100,  16'd0,     16'd7,    1'b0};
    vt[3] = '{16'd5,    16'd0,    16'hFFFF,  16'd5,    1'b1};
    vt[4] = '{16'd0,    16'd5,    16'd0,     16'd0,    1'b0};
    vt[5] = '{16'hFFFF, 16'hFFFF, 16'd1,     16'd0,    1'b0};
    vt[6] = '{16'h8000, 16'd3,    16'd10922, 16'd2,    1'b0};
    vt[7] = '{16'd0,    16'd0,    16'hFFFF,  16'd0,    1'b1};
    vt[8] = '{16'hFFFE, 16'hFFFF, 16'd0,     16'hFFFE, 1'b0};

    // Reset.
    rst_n = 1'b0; dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
    repeat (2) @(negedge clk);
    check("rst busy", dif.busy, 0);
    check("rst done", dif.done, 0);
    check("rst quotient", dif.quotient, 0);
    check("rst remainder", dif.remainder, 0);
    check("rst dz", dif.div_by_zero, 0);
    check("rst state", 32'(dif.state), 32'(DIV_IDLE));
    rst_n = 1'b1;

    // Vector table.
    foreach (vt[i])
      run_one($sformatf("vec%0d", i), vt[i].dvd, vt[i].dvs, vt[i].eq, vt[i].er, vt[i].edz);

    // Start while running is ignored.
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 16'd100; dif.divisor = 16'd7;
    @(negedge clk);
    dif.start = 1'b0;
    cyc = 1;
    while (!dif.done && cyc < 60) begin
      if (cyc == 3) begin dif.start = 1'b1; dif.dividend = 16'd9; dif.divisor = 16'd3; end
      else dif.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    dif.start = 1'b0;
    check("ign latency", cyc, N + 1);
    check("ign quotient", dif.quotient, 14);
    check("ign remainder", dif.remainder, 2);

    // Start held through DONE: back-to-back accept.
    dif.start = 1'b1; dif.dividend = 16'd9; dif.divisor = 16'd3;
    @(negedge clk);
    dif.start = 1'b0;
    cyc = 1;
    check("b2b done_low", dif.done, 0);
    check("b2b busy", dif.busy, 1);
    check("b2b held_q", dif.quotient, 14);
    while (!dif.done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b latency", cyc, N + 1);
    check("b2b quotient", dif.quotient, 3);
    check("b2b remainder", dif.remainder, 0);
    @(negedge clk);

    // Reset mid-run after a divide-by-zero left nonzero results.
    run_one("dz_pre", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 16'd100; dif.divisor = 16'd7;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst busy", dif.busy, 0);
    check("arst done", dif.done, 0);
    check("arst quotient", dif.quotient, 0);
    check("arst remainder", dif.remainder, 0);
    check("arst dz", dif.div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= dif.done;
    end
    check("arst no_done", seen, 0);
    run_one("post_rst", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);

    // Random operands against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      rdvd = N'($urandom);
      if (sel == 0)     rdvs = '0;
      else if (sel < 4) rdvs = N'($urandom_range(1, 15));
      else              rdvs = N'($urandom_range(1, 65535));
      model(rdvd, rdvs, req, rer, redz);
      run_one($sformatf("rnd%0d", k), rdvd, rdvs, req, rer, redz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
